axi_traffic_chk: RTL and testbench
==================================

Name: axi_traffic_chk

Overview:
- Parametrised AXI4 (AW/W/B/AR/R subset) traffic master and data checker for DDR SDRAM controller benches; next generation of the fixed-pattern bench master.
- Writes bursts over a configurable address window with selectable data patterns, reads them back, compares every beat and counts mismatches.
- Adds beyond the previous master: run-time start/stop, pattern modes, per-pass burst length, finite or endless pass count, and done/busy status.
- Sits between the bench top and the controller's AXI slave port, in the controller's `clk` domain.

Parameters:
- A_WIDTH, 26, AXI byte-address width.
- A_WIDTH_TEST, 12, log2 of the tested window in bytes; addresses wrap inside [0, 2^A_WIDTH_TEST).
- D_WIDTH, 16, data width; must equal 8<<D_LEVEL.
- D_LEVEL, 1, log2 of bytes per beat; beat stride = 1<<D_LEVEL bytes.
- NUM_PASSES, 0, number of full-window write+read passes; 0 = run until `start` deasserts.
- ERR_W, 16, error counter width.

Ports:
- clk  in  1  clock
- rstn  in  1  async active-low reset
- start  in  1  level; rising edge from IDLE begins a run; low stops after the current read burst
- mode  in  2  0 = address, 1 = ~address, 2 = LFSR, 3 = walking-one; sampled at start
- blen  in  8  AXI len (beats-1), sampled at start
- awvalid/awready/awaddr[A_WIDTH]/awlen[8]  out/in/out/out  write address channel
- wvalid/wready/wlast/wdata[D_WIDTH]  out/in/out/out  write data channel
- bvalid/bready  in/out  write response channel
- arvalid/arready/araddr[A_WIDTH]/arlen[8]  out/in/out/out  read address channel
- rvalid/rready/rlast/rdata[D_WIDTH]  in/out/in/in  read data channel
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse on return to IDLE
- error  out  1  registered; high for one cycle after a mismatching beat
- error_cnt  out  ERR_W  saturating mismatch count; cleared at start

Behaviour:
- Reset: all valid/ready/last/busy/done/error = 0, error_cnt = 0, addresses = 0, FSM = IDLE.
- FSM states: IDLE -> AW -> W -> B -> AR -> R -> NEXT. NEXT goes to AW, or to IDLE when the pass limit is reached or `start` is low.
  - A full write pass over the window precedes the full read pass, so the state sequence is per burst.
  - A write pointer and a read pointer advance independently.
  - Phase bit: WR until the write pointer wraps, then RD until the read pointer wraps; this ends one pass.
- AW: awvalid = 1, awaddr = write pointer, awlen = blen. Hold all values stable until awready. Then move to W.
- W: wvalid held; beat advances on wvalid & wready. wlast = 1 exactly on beat blen. After the last handshake, move to B.
- B: bready = 1. On bvalid, move to NEXT. No AW/AR is issued while in B; one outstanding transaction only.
- AR and R mirror AW and W. rready = 1 in R.
  - Each rvalid & rready beat is compared with the pattern regenerated from its address.
  - rlast is expected on beat blen. rlast on another beat, or missing on beat blen, counts as one error.
- Burst address step = (blen+1)<<D_LEVEL bytes.
  - Pointer arithmetic is modulo 2^A_WIDTH_TEST; upper address bits are 0.
  - A burst that would cross the window end is truncated: len = beats remaining - 1.
- Patterns, from beat byte-address a (zero-extended or truncated to D_WIDTH):
  - mode 0: a
  - mode 1: ~a
  - mode 2: 32-bit Galois LFSR, polynomial 0x80200003, seeded with a|1 and stepped D_LEVEL+1 times; take the low D_WIDTH bits (replicated if D_WIDTH > 32).
  - mode 3: 1 << (a>>D_LEVEL mod D_WIDTH).
- Compare stage is registered: error and error_cnt update one cycle after the beat. error_cnt saturates at all-ones.
- Throughput: channels are driven combinationally from the state, so back-to-back beats are possible at one per cycle.
- `start` dropping mid-burst:
  - The current burst completes, including B or R.
  - If the phase is WR, one read pass over the bursts written so far is performed before IDLE.
  - No AXI handshake is ever abandoned.
- `done` pulses for one cycle on entering IDLE. busy falls in the same cycle.
- Async reset mid-burst forces IDLE immediately; this is the only AXI-violating abort.

Decomposition:
- Package axi_traffic_pkg:
  - state enum
  - mode enum
  - LFSR polynomial constant
  - function pattern(mode, addr) shared by generator and checker
- Sub-module axi_traffic_cmp: registered compare plus saturating counter. All other logic stays in the top.

Test Plan:
- Ideal slave (always ready, memory model), mode 0, blen=7, window 2^12, NUM_PASSES=1 -> 256 write bursts, then 256 reads with awaddr 0x000, 0x010, …, 0xFF0; error_cnt = 0; done pulses once.
- Slave with random ready/valid stalls (30%), mode 2 -> AW/W signals stable while stalled, error_cnt = 0.
- Memory model flips bit 3 of address 0x024 -> exactly one error pulse, error_cnt = 1, in every mode.
- blen=12 (13-beat bursts, 26 B), window 4096 -> final burst truncated to awlen = 6, pointer wraps to 0x000.
- start deasserted during the third write burst -> that burst plus B completes, 3 read bursts are issued, done = 1, no further AW.
- Slave returns rlast on beat 5 of 8 -> error_cnt increments by 1. rstn pulsed mid-W -> all outputs 0 next cycle.

Source files
------------

// File: rtl/axi_traffic_pkg.sv
// Shared types and the data-pattern generator used by both the write-data
// path and the read-back checker of the AXI traffic master.
package axi_traffic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_AR,
        ST_R,
        ST_NEXT
    } state_t;

    typedef enum logic [1:0] {
        MODE_ADDR,
        MODE_NADDR,
        MODE_LFSR,
        MODE_WALK
    } mode_t;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    // Patterns are produced 64 bits wide; callers keep the low D_WIDTH bits.
    localparam int PAT_W = 64;

    // Data expected at beat byte-address addr. The LFSR is seeded with addr|1
    // and stepped d_level+1 times; its 32-bit state is replicated so that
    // data paths wider than 32 bits still see a full-width pattern.
    function automatic logic [PAT_W-1:0] pattern(mode_t mode, logic [PAT_W-1:0] addr,
                                                 int d_level, int d_width);
        logic [31:0]      s;
        logic [PAT_W-1:0] r;
        s = addr[31:0] | 32'd1;
        for (int i = 0; i < 8; i++) begin
            if (i <= d_level) begin
                s = s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
            end
        end
        case (mode)
            MODE_ADDR:  r = addr;
            MODE_NADDR: r = ~addr;
            MODE_LFSR:  r = {s, s};
            default:    r = PAT_W'(1) << ((addr >> d_level) % PAT_W'(d_width));
        endcase
        return r;
    endfunction

endpackage

// File: rtl/axi_traffic_cmp.sv
// Registered read-data compare with a saturating mismatch counter.
module axi_traffic_cmp
    import axi_traffic_pkg::*;
#(
    parameter int D_WIDTH = 16,
    parameter int ERR_W   = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               clr,
    input  logic               vld_p0,
    input  logic               last_ok_p0,
    input  logic [D_WIDTH-1:0] rdata_p0,
    input  logic [D_WIDTH-1:0] exp_p0,
    output logic               error,
    output logic [ERR_W-1:0]   error_cnt
);

    logic             miss_p0;
    logic             err_p1;
    logic [ERR_W-1:0] cnt_p1;

    // Counter sticks at all-ones instead of wrapping back to a clean count.
    function automatic logic [ERR_W-1:0] sat_inc(logic [ERR_W-1:0] v);
        return (v == '1) ? v : v + ERR_W'(1);
    endfunction

    // A beat with wrong data and a wrong rlast still counts as a single error.
    assign miss_p0 = vld_p0 && ((rdata_p0 != exp_p0) || !last_ok_p0);

    // p0 -> p1: compare result registered; counter cleared when a run starts
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_p1 <= 1'b0;
            cnt_p1 <= '0;
        end else begin
            err_p1 <= miss_p0;
            if (clr) begin
                cnt_p1 <= '0;
            end else if (miss_p0) begin
                cnt_p1 <= sat_inc(cnt_p1);
            end
        end
    end

    assign error     = err_p1;
    assign error_cnt = cnt_p1;

endmodule

// File: rtl/axi_traffic_chk.sv
// AXI4 traffic master: writes a pattern over an address window burst by
// burst, reads it back and counts mismatching beats. One transaction is
// outstanding at a time; every channel is driven straight from the state.
module axi_traffic_chk
    import axi_traffic_pkg::*;
#(
    parameter int A_WIDTH      = 26,
    parameter int A_WIDTH_TEST = 12,
    parameter int D_WIDTH      = 16,
    parameter int D_LEVEL      = 1,
    parameter int NUM_PASSES   = 0,
    parameter int ERR_W        = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [7:0]         blen,
    output logic               awvalid,
    input  logic               awready,
    output logic [A_WIDTH-1:0] awaddr,
    output logic [7:0]         awlen,
    output logic               wvalid,
    input  logic               wready,
    output logic               wlast,
    output logic [D_WIDTH-1:0] wdata,
    input  logic               bvalid,
    output logic               bready,
    output logic               arvalid,
    input  logic               arready,
    output logic [A_WIDTH-1:0] araddr,
    output logic [7:0]         arlen,
    input  logic               rvalid,
    output logic               rready,
    input  logic               rlast,
    input  logic [D_WIDTH-1:0] rdata,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [ERR_W-1:0]   error_cnt
);

    localparam int         PW  = A_WIDTH_TEST;
    localparam logic [PW:0] WIN = (PW+1)'(1) << PW;

    state_t        state, nstate;
    mode_t         cfg_mode;
    logic [7:0]    cfg_blen, beat, cur_len;
    logic [PW-1:0] wr_ptr, rd_ptr, rd_end, cur_ptr, next_ptr, beat_addr;
    logic [PW:0]   rem_beats, blen_p1, len_beats, ptr_sum;
    logic [31:0]   pass_cnt;
    logic          phase_rd, stopping, start_q;
    logic          start_rise, wrap, last_beat, pass_end, limit_hit;
    logic [D_WIDTH-1:0] pat_data;

    // Burst geometry: the burst is clipped at the window end so the pointer
    // lands exactly on 0 when the window has been covered.
    assign cur_ptr    = phase_rd ? rd_ptr : wr_ptr;
    assign rem_beats  = (WIN - {1'b0, cur_ptr}) >> D_LEVEL;
    assign blen_p1    = (PW+1)'(cfg_blen) + (PW+1)'(1);
    assign len_beats  = (blen_p1 > rem_beats) ? rem_beats : blen_p1;
    assign cur_len    = 8'(len_beats - (PW+1)'(1));
    assign ptr_sum    = {1'b0, cur_ptr} + (len_beats << D_LEVEL);
    assign wrap       = ptr_sum[PW];
    assign next_ptr   = ptr_sum[PW-1:0];
    assign beat_addr  = cur_ptr + (PW'(beat) << D_LEVEL);
    assign last_beat  = (beat == cur_len);
    assign start_rise = start && !start_q;
    assign pass_end   = (next_ptr == rd_end);
    assign limit_hit  = (NUM_PASSES != 0) && ((pass_cnt + 32'd1) >= 32'(NUM_PASSES));
    assign pat_data   = D_WIDTH'(pattern(cfg_mode, PAT_W'(beat_addr), D_LEVEL, D_WIDTH));

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= nstate;
        end
    end

    // Next-state: a stop request in the write phase still reads back what was
    // written; in a normal read phase it ends the run after the current burst.
    always_comb begin
        nstate = state;
        case (state)
            ST_IDLE: if (start_rise) nstate = ST_AW;
            ST_AW:   if (awready) nstate = ST_W;
            ST_W:    if (wready && last_beat) nstate = ST_B;
            ST_B:    if (bvalid) nstate = ST_NEXT;
            ST_AR:   if (arready) nstate = ST_R;
            ST_R:    if (rvalid && last_beat) nstate = ST_NEXT;
            ST_NEXT: begin
                if (!phase_rd) begin
                    nstate = (wrap || !start) ? ST_AR : ST_AW;
                end else if (pass_end) begin
                    nstate = (limit_hit || !start || stopping) ? ST_IDLE : ST_AW;
                end else begin
                    nstate = (!start && !stopping) ? ST_IDLE : ST_AR;
                end
            end
            default: nstate = ST_IDLE;
        endcase
    end

    // Channel controls decoded from the state
    always_comb begin
        awvalid = (state == ST_AW);
        wvalid  = (state == ST_W);
        wlast   = (state == ST_W) && last_beat;
        bready  = (state == ST_B);
        arvalid = (state == ST_AR);
        rready  = (state == ST_R);
        busy    = (state != ST_IDLE);
    end

    assign awaddr = A_WIDTH'(wr_ptr);
    assign araddr = A_WIDTH'(rd_ptr);
    assign awlen  = cur_len;
    assign arlen  = cur_len;
    assign wdata  = pat_data;

    // Run bookkeeping: config capture, pointers, beat counter, pass tracking
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            start_q  <= 1'b0;
            done     <= 1'b0;
            cfg_mode <= MODE_ADDR;
            cfg_blen <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_end   <= '0;
            phase_rd <= 1'b0;
            stopping <= 1'b0;
            pass_cnt <= '0;
            beat     <= '0;
        end else begin
            start_q <= start;
            done    <= (state == ST_NEXT) && (nstate == ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (start_rise) begin
                        cfg_mode <= mode_t'(mode);
                        cfg_blen <= blen;
                        wr_ptr   <= '0;
                        rd_ptr   <= '0;
                        rd_end   <= '0;
                        phase_rd <= 1'b0;
                        stopping <= 1'b0;
                        pass_cnt <= '0;
                        beat     <= '0;
                    end
                end
                ST_W: if (wready) beat <= last_beat ? 8'd0 : beat + 8'd1;
                ST_R: if (rvalid) beat <= last_beat ? 8'd0 : beat + 8'd1;
                ST_NEXT: begin
                    if (!phase_rd) begin
                        wr_ptr <= next_ptr;
                        if (wrap || !start) begin
                            phase_rd <= 1'b1;
                            rd_end   <= next_ptr;
                            stopping <= !start;
                        end
                    end else begin
                        rd_ptr <= next_ptr;
                        if (pass_end) begin
                            phase_rd <= 1'b0;
                            wr_ptr   <= '0;
                            rd_ptr   <= '0;
                            rd_end   <= '0;
                            stopping <= 1'b0;
                            pass_cnt <= pass_cnt + 32'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    axi_traffic_cmp #(
        .D_WIDTH (D_WIDTH),
        .ERR_W   (ERR_W)
    ) u_cmp (
        .clk        (clk),
        .rstn       (rstn),
        .clr        (state == ST_IDLE && start_rise),
        .vld_p0     (state == ST_R && rvalid),
        .last_ok_p0 (rlast == last_beat),
        .rdata_p0   (rdata),
        .exp_p0     (pat_data),
        .error      (error),
        .error_cnt  (error_cnt)
    );

endmodule

// File: tb/tb_axi_traffic_chk.sv
// Bench for axi_traffic_chk: randomly stalling AXI slave with a memory,
// expected bursts/beats queued per run from a window-level model, and a
// monitor that pops and compares on every handshake.
module tb_axi_traffic_chk;

    localparam int AW = 26;
    localparam int DW = 16;
    localparam int DL = 1;
    localparam int EW = 16;
    localparam int WIN = 4096;

    typedef struct { int addr; int len; } burst_t;
    typedef struct { logic [15:0] data; logic last; } beat_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [7:0]    blen = 8'd0;
    logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic          arvalid, arready, rvalid, rready, rlast;
    logic [AW-1:0] awaddr, araddr;
    logic [7:0]    awlen, arlen;
    logic [DW-1:0] wdata, rdata;
    logic          busy, done, error;
    logic [EW-1:0] error_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    burst_t aw_q[$];
    burst_t ar_q[$];
    beat_t  w_q[$];

    int stall_pct = 0;
    bit flip_en = 0;
    bit rlast_inj = 0;
    int aw_hs = 0, ar_hs = 0, done_cnt = 0, err_pulses = 0;
    int last_awaddr = 0, last_awlen = 0;
    logic [15:0] mem [0:WIN/2-1];

    axi_traffic_chk #(
        .A_WIDTH(AW), .A_WIDTH_TEST(12), .D_WIDTH(DW), .D_LEVEL(DL),
        .NUM_PASSES(1), .ERR_W(EW)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .mode(mode), .blen(blen),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata),
        .bvalid(bvalid), .bready(bready),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .rvalid(rvalid), .rready(rready), .rlast(rlast), .rdata(rdata),
        .busy(busy), .done(done), .error(error), .error_cnt(error_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected data at byte address a, written from the pattern definitions.
    function automatic logic [15:0] model_pat(int m, int a);
        logic [31:0] s;
        case (m)
            0: return 16'(a);
            1: return ~16'(a);
            2: begin
                s = 32'(a) | 32'd1;
                repeat (DL + 1) begin
                    if (s[0]) s = (s >> 1) ^ 32'h8020_0003;
                    else      s = s >> 1;
                end
                return s[15:0];
            end
            default: return 16'(1 << ((a / 2) % 16));
        endcase
    endfunction

    // Expected write and read bursts over the window, max_b = 0 means all.
    task automatic build(input int m, input int bl, input int max_b);
        int a = 0;
        int n = 0;
        int beats;
        while (a < WIN && (max_b == 0 || n < max_b)) begin
            beats = bl + 1;
            if (beats > (WIN - a) / 2) beats = (WIN - a) / 2;
            aw_q.push_back(burst_t'{a, beats - 1});
            ar_q.push_back(burst_t'{a, beats - 1});
            for (int i = 0; i < beats; i++)
                w_q.push_back(beat_t'{model_pat(m, a + 2 * i), (i == beats - 1)});
            a += beats * 2;
            n++;
        end
    endtask

    function automatic bit go();
        return ($urandom_range(99, 0) >= stall_pct);
    endfunction

    // Slave: drives handshake signals at the falling edge, memory behind it
    initial begin
        int wa = 0, wl = 0, wb = 0, ra = 0, rl = 0, rb = 0, a;
        bit b_pend = 0, b_held = 0, r_act = 0, r_held = 0;
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rlast = 0; rdata = '0;
        for (int i = 0; i < WIN / 2; i++) mem[i] = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rlast = 0;
                b_pend = 0; b_held = 0; r_act = 0; r_held = 0;
                continue;
            end
            bvalid = b_pend && (b_held || go());
            b_held = bvalid && !bready;
            if (bvalid && bready) b_pend = 0;

            rvalid = r_act && (r_held || go());
            a = (ra + 2 * rb) % WIN;
            rdata = mem[a / 2] ^ ((flip_en && a == 36) ? 16'h0008 : 16'h0000);
            rlast = (rb == rl) || (rlast_inj && ra == 0 && rb == 4);
            r_held = rvalid && !rready;
            if (rvalid && rready) begin
                rb++;
                if (rb > rl) r_act = 0;
            end

            awready = go();
            if (awvalid && awready) begin wa = int'(awaddr); wl = int'(awlen); wb = 0; end
            wready = go();
            if (wvalid && wready) begin
                mem[((wa + 2 * wb) % WIN) / 2] = wdata;
                wb++;
                if (wlast) b_pend = 1;
            end
            arready = go();
            if (arvalid && arready) begin ra = int'(araddr); rl = int'(arlen); rb = 0; r_act = 1; end
        end
    end

    // Monitor: pops expected items on each handshake, checks stall stability
    initial begin
        bit aw_stall = 0, w_stall = 0;
        logic [AW-1:0] p_awaddr = '0;
        logic [7:0] p_awlen = '0;
        logic [DW-1:0] p_wdata = '0;
        logic p_wlast = 0;
        burst_t b;
        beat_t  t;
        forever begin
            @(negedge clk);
            #1;
            if (!rstn) begin aw_stall = 0; w_stall = 0; continue; end
            if (aw_stall) begin
                chk("aw_hold_valid", awvalid, 1);
                chk("aw_hold_addr", awaddr, p_awaddr);
                chk("aw_hold_len", awlen, p_awlen);
            end
            if (w_stall) begin
                chk("w_hold_valid", wvalid, 1);
                chk("w_hold_data", wdata, p_wdata);
                chk("w_hold_last", wlast, p_wlast);
            end
            aw_stall = awvalid && !awready; p_awaddr = awaddr; p_awlen = awlen;
            w_stall = wvalid && !wready; p_wdata = wdata; p_wlast = wlast;
            if (awvalid && awready) begin
                aw_hs++; last_awaddr = int'(awaddr); last_awlen = int'(awlen);
                chk("aw_expected", aw_q.size() != 0, 1);
                if (aw_q.size() != 0) begin
                    b = aw_q.pop_front();
                    chk("awaddr", awaddr, b.addr);
                    chk("awlen", awlen, b.len);
                end
            end
            if (wvalid && wready) begin
                chk("w_expected", w_q.size() != 0, 1);
                if (w_q.size() != 0) begin
                    t = w_q.pop_front();
                    chk("wdata", wdata, t.data);
                    chk("wlast", wlast, t.last);
                end
            end
            if (arvalid && arready) begin
                ar_hs++;
                chk("ar_expected", ar_q.size() != 0, 1);
                if (ar_q.size() != 0) begin
                    b = ar_q.pop_front();
                    chk("araddr", araddr, b.addr);
                    chk("arlen", arlen, b.len);
                end
            end
            if (error) err_pulses++;
            if (done) begin
                done_cnt++;
                chk("busy_at_done", busy, 0);
            end
        end
    end

    task automatic clear_sb();
        aw_q.delete(); ar_q.delete(); w_q.delete();
        aw_hs = 0; ar_hs = 0; done_cnt = 0; err_pulses = 0;
    endtask

    task automatic run(input int m, input int bl, input int stall, input bit flip,
                       input bit rinj, input int stop_after, input int exp_err);
        int cyc = 0;
        clear_sb();
        mode = 2'(m); blen = 8'(bl); stall_pct = stall; flip_en = flip; rlast_inj = rinj;
        build(m, bl, stop_after);
        @(negedge clk);
        start = 1;
        while (done_cnt == 0 && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (stop_after > 0 && start && aw_hs >= stop_after && wvalid) start = 0;
        end
        chk("done_seen", done_cnt != 0, 1);
        repeat (20) @(negedge clk);
        start = 0;
        #3;
        chk("done_once", done_cnt, 1);
        chk("busy_idle", busy, 0);
        chk("error_cnt", error_cnt, exp_err);
        chk("error_pulses", err_pulses, exp_err);
        chk("aw_left", aw_q.size(), 0);
        chk("ar_left", ar_q.size(), 0);
        chk("w_left", w_q.size(), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_awvalid"}, awvalid, 0);
        chk({tag, "_wvalid"}, wvalid, 0);
        chk({tag, "_wlast"}, wlast, 0);
        chk({tag, "_bready"}, bready, 0);
        chk({tag, "_arvalid"}, arvalid, 0);
        chk({tag, "_rready"}, rready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_error_cnt"}, error_cnt, 0);
        chk({tag, "_awaddr"}, awaddr, 0);
        chk({tag, "_araddr"}, araddr, 0);
    endtask

    initial begin
        int cyc;
        repeat (3) @(negedge clk);
        #2;
        chk_all_zero("reset");
        rstn = 1;

        // Ideal slave, address pattern, 8-beat bursts over the whole window
        run(0, 7, 0, 0, 0, 0, 0);
        chk("t1_aw_count", aw_hs, 256);
        chk("t1_ar_count", ar_hs, 256);
        chk("t1_last_awaddr", last_awaddr, 'hFF0);

        // Random stalls with the LFSR pattern
        run(2, 15, 30, 0, 0, 0, 0);

        // Single flipped bit on read-back, every pattern mode
        for (int m = 0; m < 4; m++) run(m, 255, 10, 1, 0, 0, 1);

        // 13-beat bursts: final burst clipped at the window end
        run(1, 12, 0, 0, 0, 0, 0);
        chk("t4_last_awaddr", last_awaddr, 'hFF2);
        chk("t4_last_awlen", last_awlen, 6);

        // Stop during the third write burst, early rlast on first read burst
        run(3, 7, 20, 0, 1, 3, 1);
        chk("t5_aw_count", aw_hs, 3);
        chk("t5_ar_count", ar_hs, 3);

        // Asynchronous reset in the middle of a write burst
        clear_sb();
        mode = 2'd0; blen = 8'd7; stall_pct = 0; flip_en = 0; rlast_inj = 0;
        build(0, 7, 0);
        @(negedge clk);
        start = 1;
        cyc = 0;
        while (!(aw_hs >= 2 && wvalid) && cyc < 2000) begin @(negedge clk); cyc++; end
        chk("t6_reached_w", wvalid, 1);
        rstn = 0;
        #2;
        chk_all_zero("midrst");
        @(posedge clk);
        #1;
        chk("midrst_busy_next", busy, 0);
        chk("midrst_wvalid_next", wvalid, 0);
        start = 0;
        repeat (3) @(negedge clk);
        rstn = 1;

        // Recovery after reset: short stopped run
        run(0, 7, 0, 0, 0, 1, 0);
        chk("t7_aw_count", aw_hs, 1);
        chk("t7_ar_count", ar_hs, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
